program_counter: RTL and testbench

- Instruction-address register for the MIPS core; drives the instruction-memory address (W=6 covers a 64-entry ISM).
- Each clock, either advances sequentially or loads a branch target selected by `mux_sel`.
- Sits between the branch/control logic, which supplies `mux_sel` and `branch`, and instruction fetch, which consumes `out`.

---
 rtl/program_counter_pkg.sv | 14 +
 rtl/program_counter_next_mux.sv | 36 +++
 rtl/program_counter.sv | 43 ++++
 tb/tb_program_counter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/program_counter_pkg.sv
// Shared defaults and the next-PC select encoding for the program counter.
`timescale 1ns/1ps
package pc_pkg;

    localparam int PC_W_DEFAULT     = 6;
    localparam int PC_STEP_DEFAULT  = 1;
    localparam int PC_RESET_DEFAULT = 0;

    typedef enum logic {
        PC_SEQ    = 1'b0,
        PC_BRANCH = 1'b1
    } pc_sel_e;

endpackage

// File: rtl/program_counter_next_mux.sv
// Combinational next-PC: incrementer plus branch select.
// Defining PC_BRANCH_REL_EN turns the branch input into a signed offset from PC+STEP.
`timescale 1ns/1ps
module pc_next_mux
    import pc_pkg::*;
#(
    parameter int W    = PC_W_DEFAULT,
    parameter int STEP = PC_STEP_DEFAULT
) (
    input  logic [W-1:0] pc_i,
    input  pc_sel_e      sel_i,
    input  logic [W-1:0] branch_i,
    output logic [W-1:0] next_o
);

    localparam logic [W-1:0] STEP_W = W'(STEP);

    logic [W-1:0] seq_pc;
    logic [W-1:0] target_pc;

    // All sums are W bits wide, so wrap-around past 2^W-1 is implicit.
    assign seq_pc = pc_i + STEP_W;

`ifdef PC_BRANCH_REL_EN
    assign target_pc = seq_pc + branch_i;
`else
    assign target_pc = branch_i;
`endif

    // Compare-then-select so an unknown select yields an unknown PC.
    always_comb begin
        next_o = seq_pc;
        next_o = (sel_i == PC_BRANCH) ? target_pc : seq_pc;
    end

endmodule

// File: rtl/program_counter.sv
// Instruction-address register: async active-low clear, next value from pc_next_mux.
// Optional macro PC_BRANCH_REL_EN selects PC-relative branches (handled in pc_next_mux).
`timescale 1ns/1ps
module program_counter
    import pc_pkg::*;
#(
    parameter int W         = PC_W_DEFAULT,
    parameter int RESET_VAL = PC_RESET_DEFAULT,
    parameter int STEP      = PC_STEP_DEFAULT
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         mux_sel,
    input  logic [W-1:0] branch,
    output logic [W-1:0] out
);

    localparam logic [W-1:0] RESET_W = W'(RESET_VAL);

    logic [W-1:0] pc_q;
    logic [W-1:0] pc_d;

    pc_next_mux #(
        .W    (W),
        .STEP (STEP)
    ) u_next (
        .pc_i     (pc_q),
        .sel_i    (pc_sel_e'(mux_sel)),
        .branch_i (branch),
        .next_o   (pc_d)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pc_q <= RESET_W;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign out = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed, table-driven bench for program_counter (W=6, STEP=1, 2ns clock).
`timescale 1ns/1ps
module tb_program_counter;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         clr;
    logic         mux_sel;
    logic [7:0]   branch_wide;
    logic [W-1:0] out;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic         clr;
        logic         sel;
        logic [7:0]   br;
        logic [W-1:0] exp;
        string        name;
    } vec_t;

    vec_t vecs[$];

    program_counter #(
        .W         (W),
        .RESET_VAL (0),
        .STEP      (1)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .mux_sel (mux_sel),
        .branch  (branch_wide[W-1:0]),
        .out     (out)
    );

    always #1 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] exp);
        tests_run++;
        if (out !== exp) begin
            tests_failed++;
            $display("FAIL %s: out=%0d expected=%0d at t=%0t", name, out, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; result is checked one full cycle later.
    task automatic apply(input logic c, input logic s, input logic [7:0] b,
                         input logic [W-1:0] exp, input string name);
        clr         = c;
        mux_sel     = s;
        branch_wide = b;
        @(negedge clk);
        check(name, exp);
    endtask

    function automatic vec_t mk(input logic c, input logic s, input logic [7:0] b,
                                input logic [W-1:0] e, input string n);
        vec_t v;
        v.clr = c; v.sel = s; v.br = b; v.exp = e; v.name = n;
        return v;
    endfunction

    initial begin
        vecs.push_back(mk(1'b0, 1'b0, 8'd0, 6'd0, "reset_hold0"));
        vecs.push_back(mk(1'b0, 1'b0, 8'd0, 6'd0, "reset_hold1"));
        vecs.push_back(mk(1'b0, 1'b0, 8'd0, 6'd0, "reset_hold2"));
        vecs.push_back(mk(1'b1, 1'b0, 8'd0, 6'd1, "count1"));
        vecs.push_back(mk(1'b1, 1'b0, 8'd0, 6'd2, "count2"));
        vecs.push_back(mk(1'b1, 1'b0, 8'd0, 6'd3, "count3"));
        vecs.push_back(mk(1'b1, 1'b0, 8'd0, 6'd4, "count4"));
`ifdef PC_BRANCH_REL_EN
        vecs.push_back(mk(1'b1, 1'b1, 8'd5,  6'd10, "rel_fwd"));
        vecs.push_back(mk(1'b1, 1'b1, 8'd62, 6'd9,  "rel_back"));
        vecs.push_back(mk(1'b1, 1'b1, 8'd52, 6'd62, "rel_to62"));
        vecs.push_back(mk(1'b1, 1'b1, 8'd5,  6'd4,  "rel_wrap"));
        vecs.push_back(mk(1'b1, 1'b0, 8'd0,  6'd5,  "rel_seq"));
        vecs.push_back(mk(1'b1, 1'b1, 8'd31, 6'd37, "rel_to37"));
`else
        vecs.push_back(mk(1'b1, 1'b1, 8'd127, 6'd63, "abs_trunc"));
        vecs.push_back(mk(1'b1, 1'b0, 8'd0,   6'd0,  "seq_wrap"));
        vecs.push_back(mk(1'b1, 1'b1, 8'd20,  6'd20, "abs_20"));
        vecs.push_back(mk(1'b1, 1'b1, 8'd20,  6'd20, "abs_20_again"));
        vecs.push_back(mk(1'b1, 1'b0, 8'd0,   6'd21, "seq_21"));
        vecs.push_back(mk(1'b1, 1'b1, 8'd37,  6'd37, "abs_37"));
`endif

        // Reset asserted at t=0, before any clock edge.
        clr         = 1'b0;
        mux_sel     = 1'b0;
        branch_wide = 8'd0;
        #0.5;
        check("reset_immediate", 6'd0);
        @(negedge clk);

        foreach (vecs[i]) begin
            apply(vecs[i].clr, vecs[i].sel, vecs[i].br, vecs[i].exp, vecs[i].name);
        end

        // Mid-cycle async clear at PC=37 with a branch pending.
        mux_sel     = 1'b1;
        branch_wide = 8'd50;
        #0.3;
        clr = 1'b0;
        #0.2;
        check("async_clear_now", 6'd0);
        @(negedge clk);
        check("async_clear_held", 6'd0);
        apply(1'b1, 1'b0, 8'd0, 6'd1, "release_count1");

        // Reset dominates a held branch request across several edges.
        apply(1'b0, 1'b1, 8'd20, 6'd0, "reset_prio0");
        apply(1'b0, 1'b1, 8'd20, 6'd0, "reset_prio1");
        apply(1'b0, 1'b1, 8'd20, 6'd0, "reset_prio2");
        apply(1'b1, 1'b0, 8'd0,  6'd1, "reset_prio_release");
        apply(1'b1, 1'b0, 8'd0,  6'd2, "reset_prio_count2");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
